// File: rtl/org8_bist_checker.sv
// org8_bist_checker: BIST controller that sweeps operand vectors into a bitwise gate,
// samples its result after LAT cycles and compares against a golden OR/AND/XOR model.
module org8_bist_checker #(
    parameter int WIDTH = 8,
    parameter int LAT   = 1,
    parameter int OP    = 0,
    parameter int MODE  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] op_x,
    output logic [WIDTH-1:0] op_y,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_x,
    output logic [WIDTH-1:0] fail_y,
    output logic [WIDTH-1:0] fail_got
);
    localparam int IW = (MODE == 1) ? 2 * WIDTH : WIDTH;

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, fx_q, fx_d, fy_q, fy_d, fg_q, fg_d;
    logic [WIDTH-1:0] nx, ny, exp_v;
    logic [15:0]      err_q, err_d;
    logic             fv_q, fv_d, mis;

    if (MODE == 1) begin : g_ex
        assign nx = idx_q[2*WIDTH-1:WIDTH];
        assign ny = idx_q[WIDTH-1:0];
    end else begin : g_dg
        assign nx = idx_q;
        assign ny = idx_q;
    end

    assign exp_v = (OP == 1) ? (x_q & y_q) : (OP == 2) ? (x_q ^ y_q) : (x_q | y_q);
    assign mis   = exp_v != dut_out;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        fg_d    = fg_q;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = DRIVE;
                        idx_d   = '0;
                        err_d   = '0;
                        fv_d    = 1'b0;
                        fx_d    = '0;
                        fy_d    = '0;
                        fg_d    = '0;
                    end
                end
                DRIVE: begin
                    x_d     = nx;
                    y_d     = ny;
                    cnt_d   = 4'(LAT);
                    state_d = (LAT > 0) ? WAIT : CHECK;
                end
                WAIT: begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = (cnt_q == 4'd1) ? CHECK : WAIT;
                end
                CHECK: begin
                    if (mis) begin
                        err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                        if (!fv_q) begin
                            fv_d = 1'b1;
                            fx_d = x_q;
                            fy_d = y_q;
                            fg_d = dut_out;
                        end
                    end
                    // the all-ones index is the last vector, so idx never wraps within a run
                    if (idx_q == '1) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = DRIVE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fx_q    <= '0;
            fy_q    <= '0;
            fg_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            fg_q    <= fg_d;
        end
    end

    assign op_x       = x_q;
    assign op_y       = y_q;
    assign busy       = (state_q == DRIVE) || (state_q == WAIT) || (state_q == CHECK);
    assign done       = state_q == DONE;
    assign pass       = done && (err_q == 16'd0);
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_x     = fx_q;
    assign fail_y     = fy_q;
    assign fail_got   = fg_q;
endmodule

// File: tb/tb_org8_bist_checker.sv
// tb_org8_bist_checker: seven checker instances with different golden ops, sweeps and latencies;
// run results are queued as expectations and checked by a monitor when done rises.
module tb_org8_bist_checker;
    typedef struct packed {
        logic [2:0]  id;
        logic        pass;
        logic [15:0] err;
        logic        fv;
        logic [7:0]  fx, fy, fg;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n, start0, start1, abort0, stuck;
    logic [7:0] x_v [7], y_v [7], g_v [7], fx_v [7], fy_v [7], fg_v [7];
    logic [15:0] err_v [7];
    logic       busy_v [7], done_v [7], pass_v [7], fv_v [7], done_p [7];
    logic [3:0] x1, y1, fx1, fy1, fg1;
    logic [7:0] d2 [3], d3 [3];
    res_t       exp_q [$];
    int         tests = 0, fails = 0, n;

    always #5 clk = ~clk;

    org8_bist_checker #(.WIDTH(8), .LAT(1), .OP(0), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .op_x(x_v[0]), .op_y(y_v[0]),
        .dut_out(g_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
        .fail_valid(fv_v[0]), .fail_x(fx_v[0]), .fail_y(fy_v[0]), .fail_got(fg_v[0]));
    org8_bist_checker #(.WIDTH(4), .LAT(0), .OP(0), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .op_x(x1), .op_y(y1),
        .dut_out(x1 & y1), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
        .fail_valid(fv_v[1]), .fail_x(fx1), .fail_y(fy1), .fail_got(fg1));
    org8_bist_checker #(.WIDTH(8), .LAT(3), .OP(0), .MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .op_x(x_v[2]), .op_y(y_v[2]),
        .dut_out(g_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[2]),
        .fail_valid(fv_v[2]), .fail_x(fx_v[2]), .fail_y(fy_v[2]), .fail_got(fg_v[2]));
    org8_bist_checker #(.WIDTH(8), .LAT(2), .OP(0), .MODE(0)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .op_x(x_v[3]), .op_y(y_v[3]),
        .dut_out(g_v[3]), .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .err_count(err_v[3]),
        .fail_valid(fv_v[3]), .fail_x(fx_v[3]), .fail_y(fy_v[3]), .fail_got(fg_v[3]));
    org8_bist_checker #(.WIDTH(8), .LAT(1), .OP(2), .MODE(0)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .op_x(x_v[4]), .op_y(y_v[4]),
        .dut_out(g_v[4]), .busy(busy_v[4]), .done(done_v[4]), .pass(pass_v[4]), .err_count(err_v[4]),
        .fail_valid(fv_v[4]), .fail_x(fx_v[4]), .fail_y(fy_v[4]), .fail_got(fg_v[4]));
    org8_bist_checker #(.WIDTH(8), .LAT(1), .OP(1), .MODE(0)) u5 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .op_x(x_v[5]), .op_y(y_v[5]),
        .dut_out(g_v[5]), .busy(busy_v[5]), .done(done_v[5]), .pass(pass_v[5]), .err_count(err_v[5]),
        .fail_valid(fv_v[5]), .fail_x(fx_v[5]), .fail_y(fy_v[5]), .fail_got(fg_v[5]));
    org8_bist_checker #(.WIDTH(8), .LAT(1), .OP(3), .MODE(0)) u6 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .op_x(x_v[6]), .op_y(y_v[6]),
        .dut_out(g_v[6]), .busy(busy_v[6]), .done(done_v[6]), .pass(pass_v[6]), .err_count(err_v[6]),
        .fail_valid(fv_v[6]), .fail_x(fx_v[6]), .fail_y(fy_v[6]), .fail_got(fg_v[6]));

    assign x_v[1]  = {4'd0, x1};
    assign y_v[1]  = {4'd0, y1};
    assign g_v[1]  = {4'd0, x1 & y1};
    assign fx_v[1] = {4'd0, fx1};
    assign fy_v[1] = {4'd0, fy1};
    assign fg_v[1] = {4'd0, fg1};
    assign g_v[0]  = (x_v[0] | y_v[0]) & (stuck ? 8'hF7 : 8'hFF);
    assign g_v[2]  = d2[2];
    assign g_v[3]  = d3[2];
    assign g_v[4]  = x_v[4] | y_v[4];
    assign g_v[5]  = x_v[5] ^ y_v[5];
    assign g_v[6]  = x_v[6] | y_v[6];

    // three-register pipelined OR gate for the latency tests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                d2[i] <= 8'd0;
                d3[i] <= 8'd0;
            end
        end else begin
            d2[0] <= x_v[2] | y_v[2];
            d2[1] <= d2[0];
            d2[2] <= d2[1];
            d3[0] <= x_v[3] | y_v[3];
            d3[1] <= d3[0];
            d3[2] <= d3[1];
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic p, input int err, input logic fv,
                            input logic [7:0] fx, input logic [7:0] fy, input logic [7:0] fg);
        exp_q.push_back(res_t'{id[2:0], p, err[15:0], fv, fx, fy, fg});
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start0();
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
    endtask

    task automatic wait_done0(output int cyc);
        cyc = 0;
        while (!done_v[0] && cyc < 2000) begin
            step(1);
            cyc++;
        end
    endtask

    always @(negedge clk) begin
        int   j;
        res_t e;
        for (int k = 0; k < 7; k++) begin
            if (done_v[k] && !done_p[k]) begin
                j = -1;
                for (int i = 0; i < exp_q.size(); i++)
                    if (j < 0 && exp_q[i].id == 3'(k)) j = i;
                if (j < 0) begin
                    tests++;
                    fails++;
                    $display("FAIL u%0d_unexpected_done: got done expected none", k);
                end else begin
                    e = exp_q[j];
                    exp_q.delete(j);
                    check($sformatf("u%0d_pass", k), 64'(pass_v[k]), 64'(e.pass));
                    check($sformatf("u%0d_err", k), 64'(err_v[k]), 64'(e.err));
                    check($sformatf("u%0d_fail_valid", k), 64'(fv_v[k]), 64'(e.fv));
                    check($sformatf("u%0d_fail_xyg", k), 64'({fx_v[k], fy_v[k], fg_v[k]}),
                          64'({e.fx, e.fy, e.fg}));
                end
            end
            done_p[k] = done_v[k];
        end
    end

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        abort0 = 1'b0;
        stuck  = 1'b0;
        for (int k = 0; k < 7; k++) done_p[k] = 1'b0;
        step(3);
        check("reset_outputs", 64'({busy_v[0], done_v[0], pass_v[0], err_v[0], fv_v[0], fx_v[0],
              fy_v[0], fg_v[0], x_v[0], y_v[0]}), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        push_exp(0, 1'b1, 0, 1'b0, 8'h00, 8'h00, 8'h00);
        pulse_start0();
        check("busy_after_start", 64'(busy_v[0]), 64'd1);
        wait_done0(n);
        check("diag_cycles", 64'(n), 64'd768);

        stuck = 1'b1;
        push_exp(0, 1'b0, 128, 1'b1, 8'h08, 8'h08, 8'h00);
        pulse_start0();
        check("restart_from_done_busy", 64'({busy_v[0], done_v[0]}), 64'b10);
        wait_done0(n);
        check("stuck_cycles", 64'(n), 64'd768);

        pulse_start0();
        step(99);
        start0 = 1'b1;
        step(1);
        start0 = 1'b0;
        step(50);
        check("start_ignored_op_x", 64'(x_v[0]), 64'h31);
        check("midrun_err", 64'(err_v[0]), 64'd24);
        abort0 = 1'b1;
        step(1);
        abort0 = 1'b0;
        check("abort_idle", 64'({busy_v[0], done_v[0], pass_v[0]}), 64'd0);
        check("abort_frozen", 64'({err_v[0], fv_v[0], fx_v[0], fy_v[0]}), 64'({16'd24, 1'b1, 8'h08, 8'h08}));
        step(5);
        check("abort_stays_idle", 64'({busy_v[0], done_v[0]}), 64'd0);
        push_exp(0, 1'b0, 128, 1'b1, 8'h08, 8'h08, 8'h00);
        pulse_start0();
        check("start_clears_after_abort", 64'({err_v[0], fv_v[0], fx_v[0]}), 64'd0);
        wait_done0(n);
        check("done_after_abort_run", 64'(done_v[0]), 64'd1);

        pulse_start0();
        n = 0;
        while (x_v[0] != 8'h40 && n < 1000) begin
            step(1);
            n++;
        end
        check("reach_vector_40", 64'(x_v[0]), 64'h40);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({busy_v[0], done_v[0], pass_v[0], err_v[0], fv_v[0], fx_v[0],
              fy_v[0], fg_v[0], x_v[0], y_v[0]}), 64'd0);
        step(2);
        @(negedge clk) rst_n = 1'b1;
        push_exp(0, 1'b0, 128, 1'b1, 8'h08, 8'h08, 8'h00);
        pulse_start0();
        wait_done0(n);
        check("post_reset_cycles", 64'(n), 64'd768);

        push_exp(1, 1'b0, 240, 1'b1, 8'h00, 8'h01, 8'h00);
        push_exp(2, 1'b1, 0, 1'b0, 8'h00, 8'h00, 8'h00);
        push_exp(3, 1'b0, 255, 1'b1, 8'h01, 8'h01, 8'h00);
        push_exp(4, 1'b0, 255, 1'b1, 8'h01, 8'h01, 8'h01);
        push_exp(5, 1'b0, 255, 1'b1, 8'h01, 8'h01, 8'h00);
        push_exp(6, 1'b1, 0, 1'b0, 8'h00, 8'h00, 8'h00);
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        n = 0;
        while (!(done_v[1] && done_v[2] && done_v[3] && done_v[4] && done_v[5] && done_v[6]) && n < 2000) begin
            step(1);
            n++;
        end
        check("parallel_runs_done", 64'({done_v[1], done_v[2], done_v[3], done_v[4], done_v[5], done_v[6]}),
              64'b111111);
        step(2);
        while (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL u%0d_missing_done: got none expected done", exp_q[0].id);
            exp_q.delete(0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
